// File: rtl/multi_cycle_controller_pkg.sv
// Shared definitions for the multi-cycle RV32I controller: opcodes, mux encodings,
// FSM state encoding and the DECODE dispatch helper.
package multi_cycle_controller_pkg;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_RT   = 7'b0110011;
  localparam logic [6:0] OP_IT   = 7'b0010011;
  localparam logic [6:0] OP_BT   = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_LUI  = 7'b0110111;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_U = 3'b011;
  localparam logic [2:0] IMM_J = 3'b100;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_RTYPE = 2'b10;
  localparam logic [1:0] ALU_ITYPE = 2'b11;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_MEM    = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;
  localparam logic [1:0] RES_IMM    = 2'b11;

  typedef enum logic [4:0] {
    S_IDLE, S_FETCH, S_DECODE, S_MEM_ADR, S_MEM_RD, S_MEM_WB, S_MEM_WR,
    S_EX_R, S_EX_I, S_ALU_WB, S_EX_BR, S_EX_JAL, S_JALR_ADR, S_JALR_JMP,
    S_LUI_WB, S_ILLEGAL, S_HALT
  } state_t;

  function automatic state_t dispatch(input logic [6:0] opc);
    case (opc)
      OP_LW, OP_SW: return S_MEM_ADR;
      OP_RT:        return S_EX_R;
      OP_IT:        return S_EX_I;
      OP_BT:        return S_EX_BR;
      OP_JAL:       return S_EX_JAL;
      OP_JALR:      return S_JALR_ADR;
      OP_LUI:       return S_LUI_WB;
      default:      return S_ILLEGAL;
    endcase
  endfunction

endpackage

// File: rtl/multi_cycle_controller_branch_resolver.sv
// Combinational branch condition: BEQ/BNE/BLT/BGE from funct3 and ALU flags.
module multi_cycle_controller_branch_resolver (
  input  logic [2:0] funct3,
  input  logic       zero,
  input  logic       lt,
  output logic       taken,
  output logic       bad_funct3
);

  always_comb begin
    taken      = 1'b0;
    bad_funct3 = 1'b0;
    case (funct3)
      3'b000:  taken = zero;
      3'b001:  taken = ~zero;
      3'b100:  taken = lt;
      3'b101:  taken = ~lt;
      default: bad_funct3 = 1'b1;
    endcase
  end

endmodule

// File: rtl/multi_cycle_controller.sv
// Multi-cycle RV32I control FSM. Define MC_MEM_HANDSHAKE_EN to stall FETCH/MEM_RD/MEM_WR
// on mem_ready; otherwise every memory state completes in one cycle.
module multi_cycle_controller
  import multi_cycle_controller_pkg::*;
#(
  parameter int ALU_OP_W     = 2,
  parameter int IMM_SRC_W    = 3,
  parameter bit TRAP_ILLEGAL = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [6:0]           opc,
  input  logic [2:0]           funct3,
  input  logic                 zero,
  input  logic                 lt,
  input  logic                 mem_ready,
  output logic                 pc_write,
  output logic                 adr_src,
  output logic                 ir_write,
  output logic                 mem_write,
  output logic                 reg_write,
  output logic [1:0]           alu_src_a,
  output logic [1:0]           alu_src_b,
  output logic [1:0]           result_src,
  output logic [IMM_SRC_W-1:0] imm_src,
  output logic [ALU_OP_W-1:0]  alu_op,
  output logic                 instr_done,
  output logic                 illegal
);

  state_t state_reg, state_next;
  logic   mem_ok;
  logic   taken;
  logic   bad_funct3;

`ifdef MC_MEM_HANDSHAKE_EN
  assign mem_ok = mem_ready;
`else
  logic unused_mem_ready;
  assign unused_mem_ready = mem_ready;
  assign mem_ok = 1'b1;
`endif

  multi_cycle_controller_branch_resolver u_branch (
    .funct3     (funct3),
    .zero       (zero),
    .lt         (lt),
    .taken      (taken),
    .bad_funct3 (bad_funct3)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_reg <= S_IDLE;
    else      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:     state_next = S_FETCH;
      S_FETCH:    if (mem_ok) state_next = S_DECODE;
      S_DECODE:   state_next = dispatch(opc);
      S_MEM_ADR:  state_next = (opc == OP_SW) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:   if (mem_ok) state_next = S_MEM_WB;
      S_MEM_WB:   state_next = S_FETCH;
      S_MEM_WR:   if (mem_ok) state_next = S_FETCH;
      S_EX_R:     state_next = S_ALU_WB;
      S_EX_I:     state_next = S_ALU_WB;
      S_ALU_WB:   state_next = S_FETCH;
      S_EX_BR:    state_next = S_FETCH;
      S_EX_JAL:   state_next = S_ALU_WB;
      S_JALR_ADR: state_next = S_JALR_JMP;
      S_JALR_JMP: state_next = S_ALU_WB;
      S_LUI_WB:   state_next = S_FETCH;
      S_ILLEGAL:  state_next = TRAP_ILLEGAL ? S_HALT : S_FETCH;
      S_HALT:     state_next = S_HALT;
      default:    state_next = S_IDLE;
    endcase
  end

  always_comb begin
    pc_write   = 1'b0;
    adr_src    = 1'b0;
    ir_write   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = SRCA_PC;
    alu_src_b  = SRCB_RS2;
    result_src = RES_ALUOUT;
    imm_src    = IMM_SRC_W'(IMM_I);
    alu_op     = ALU_OP_W'(ALU_ADD);
    instr_done = 1'b0;
    illegal    = 1'b0;
    case (state_reg)
      S_FETCH: begin
        ir_write   = mem_ok;
        pc_write   = mem_ok;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALU;
      end
      // Branch/jump target is precomputed here into ALUOut.
      S_DECODE: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
        imm_src   = (opc == OP_JAL) ? IMM_SRC_W'(IMM_J) : IMM_SRC_W'(IMM_B);
      end
      S_MEM_ADR: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        imm_src   = (opc == OP_SW) ? IMM_SRC_W'(IMM_S) : IMM_SRC_W'(IMM_I);
      end
      S_MEM_RD: adr_src = 1'b1;
      S_MEM_WB: begin
        result_src = RES_MEM;
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      S_MEM_WR: begin
        adr_src    = 1'b1;
        mem_write  = mem_ok;
        instr_done = mem_ok;
      end
      S_EX_R: begin
        alu_src_a = SRCA_RS1;
        alu_op    = ALU_OP_W'(ALU_RTYPE);
      end
      S_EX_I: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        alu_op    = ALU_OP_W'(ALU_ITYPE);
      end
      S_ALU_WB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      S_EX_BR: begin
        alu_src_a  = SRCA_RS1;
        alu_op     = ALU_OP_W'(ALU_SUB);
        pc_write   = taken;
        instr_done = 1'b1;
        illegal    = bad_funct3;
      end
      S_EX_JAL, S_JALR_JMP: begin
        pc_write  = 1'b1;
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_FOUR;
      end
      S_JALR_ADR: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
      end
      S_LUI_WB: begin
        imm_src    = IMM_SRC_W'(IMM_U);
        result_src = RES_IMM;
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      S_ILLEGAL: begin
        illegal    = 1'b1;
        instr_done = ~TRAP_ILLEGAL;
      end
      S_HALT:  illegal = 1'b1;
      default: ;
    endcase
  end

endmodule
